serializer_scheduler: RTL and testbench
=======================================

Name: serializer_scheduler

Overview:
- Shares one bit-serializer between N word sources.
- Round-robin picks one pending source and hands its LENGTH-bit word to the serializer's parallel load port.
- Waits for the serializer to consume the word and finish the frame, then releases it with a one-cycle acknowledge.
- Sits between the filter's per-channel output words and the single serial output lane; tags each frame with its channel id.

Parameters:
- N_CH, 4, number of requesting channels (2..16)
- LENGTH, 24, word width in bits
- TIMEOUT, 64, max cycles waiting on any serializer event; 0 disables the watchdog
- ID_W, $clog2(N_CH), channel id width (derived, not overridden)

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_en  in  1  clock enable; low freezes all state, counters and outputs
- iv_req_valid  in  N_CH  per-channel word pending (level, held until acked)
- iv_req_data  in  N_CH*LENGTH  channel k word at bits [k*LENGTH +: LENGTH]
- ov_req_ack  out  N_CH  one-cycle pulse: channel word latched, source may drop valid
- ov_ser_din  out  LENGTH  latched word to serializer
- o_ser_din_valid  out  1  word valid to serializer, held until i_ser_ready
- i_ser_ready  in  1  serializer pulse: word consumed
- i_ser_dout_valid  in  1  serializer: frame shifted out, waiting for release
- o_ser_ack  out  1  one-cycle release to serializer
- ov_grant_id  out  ID_W  channel id of current/last frame
- o_busy  out  1  high whenever state is not IDLE
- o_frame_start  out  1  pulse on word consumed
- o_frame_done  out  1  pulse on release
- o_error  out  1  pulse on watchdog expiry

Behaviour:
- Reset: all outputs 0, state IDLE, RR pointer 0, watchdog 0, holding register 0.
- All outputs are registered.
- FSM states: IDLE, LOAD, SHIFT, RELEASE (one-hot).
- IDLE, any iv_req_valid set:
  - Grant the first set bit searching upward from pointer, wrapping N_CH-1 -> 0.
  - Latch data into ov_ser_din and set ov_grant_id.
  - Next cycle: ov_req_ack[g]=1 for exactly one cycle, o_ser_din_valid=1, o_busy=1; go to LOAD.
  - Latency: valid seen at cycle t gives ack and din_valid at t+1.
- LOAD: hold o_ser_din_valid until i_ser_ready=1.
  - Next cycle: o_ser_din_valid=0, o_frame_start pulse; go to SHIFT.
- SHIFT: wait for i_ser_dout_valid=1.
  - Next cycle: o_ser_ack=1 for one cycle; go to RELEASE.
- RELEASE: lasts exactly one cycle.
  - o_frame_done pulse.
  - Pointer <= (g+1) mod N_CH.
  - Go to IDLE; a new grant may be issued in the following cycle.
- Requests arriving while busy are not acked; they are arbitrated at the next IDLE.
- A source dropping valid before grant is simply not selected.
- i_ser_ready and i_ser_dout_valid high in the same LOAD cycle: take the LOAD exit only; dout_valid is sampled in SHIFT.
- Watchdog:
  - Counts cycles in LOAD and SHIFT; cleared on every state entry.
  - If it reaches TIMEOUT-1 without the awaited event: o_error pulse, o_ser_din_valid=0, no ack to the serializer, pointer advances past g, go to IDLE.
  - TIMEOUT=0 means the watchdog never fires.
- i_en=0: state, pointer, watchdog and all outputs hold; pulses are not re-issued when i_en returns high.
- Reset asserted mid-frame: immediate return to reset values, no ack or done pulse. The serializer is reset by the same i_rst_n.

Decomposition:
- Package serializer_sched_pkg: state encodings, ID-width helper function, TIMEOUT width constant.
- Sub-module rr_arbiter: combinational rotate-priority-rotate pick given request vector and pointer; outputs grant one-hot, grant id and any-request flag.
- The FSM, holding register and watchdog stay in serializer_scheduler.

Test Plan:
- Single channel: only ch2 valid, data 0xA5A5A5. Expected: ack[2] and din_valid at t+1, ov_ser_din=0xA5A5A5, grant_id=2; ready at t+4 gives frame_start at t+5; dout_valid at t+30 gives ser_ack at t+31 and frame_done at t+32.
- Fairness: all 4 channels valid continuously for 8 frames. Expected grant order 0,1,2,3,0,1,2,3, and no ack while o_busy.
- Wrap/skip: pointer=3, only ch1 and ch3 valid. Expected grant 3 then 1; pointer ends at 2.
- Watchdog: with TIMEOUT=64, grant then never assert i_ser_ready. Expected o_error pulse 64 cycles after LOAD entry, din_valid low, next grant goes to the next channel.
- Enable freeze: drop i_en for 10 cycles during SHIFT with dout_valid high. Expected no ser_ack and watchdog frozen; ser_ack exactly once after i_en returns.
- Reset mid-frame: assert i_rst_n=0 while in LOAD. Expected all outputs 0 asynchronously, grant restarts from ch0 after release.

Source files
------------

// File: rtl/serializer_sched_pkg.sv
// Shared constants for the serializer scheduler: one-hot FSM encodings,
// watchdog counter width and the channel-id width helper.
package serializer_sched_pkg;

  localparam logic [3:0] ST_IDLE    = 4'b0001;
  localparam logic [3:0] ST_LOAD    = 4'b0010;
  localparam logic [3:0] ST_SHIFT   = 4'b0100;
  localparam logic [3:0] ST_RELEASE = 4'b1000;

  // Watchdog counter width; bounds the largest usable TIMEOUT to 2**WD_W.
  localparam int unsigned WD_W = 16;

  function automatic int unsigned id_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: rotate requests by the pointer, take the
// lowest set bit, rotate the result back into a channel id and one-hot grant.
module rr_arbiter
  import serializer_sched_pkg::*;
#(
  parameter  int unsigned N_CH = 4,
  localparam int unsigned ID_W = id_width(N_CH)
) (
  input  logic [N_CH-1:0] req_i,
  input  logic [ID_W-1:0] ptr_i,
  output logic [N_CH-1:0] gnt_o,
  output logic [ID_W-1:0] gnt_id_o,
  output logic            any_o
);

  logic [2*N_CH-1:0] dbl;
  logic [N_CH-1:0]   rot;
  logic [ID_W-1:0]   off;
  logic [ID_W:0]     idx;
  logic              found;

  always_comb begin
    dbl   = {req_i, req_i} >> ptr_i;
    rot   = dbl[N_CH-1:0];
    off   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        off   = ID_W'(i);
      end
    end
    // ptr + off never exceeds 2*N_CH-2, so one conditional subtract is the modulo
    idx = {1'b0, ptr_i} + {1'b0, off};
    if (idx >= (ID_W+1)'(N_CH)) begin
      idx = idx - (ID_W+1)'(N_CH);
    end
    gnt_id_o = idx[ID_W-1:0];
    gnt_o    = found ? (N_CH'(1) << gnt_id_o) : '0;
    any_o    = found;
  end

endmodule

// File: rtl/serializer_scheduler.sv
// Shares one bit-serializer among N_CH word sources: round-robin grant,
// parallel load, wait for frame completion, one-cycle release, watchdog.
module serializer_scheduler
  import serializer_sched_pkg::*;
#(
  parameter  int unsigned N_CH    = 4,
  parameter  int unsigned LENGTH  = 24,
  parameter  int unsigned TIMEOUT = 64,
  localparam int unsigned ID_W    = id_width(N_CH)
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_en,
  input  logic [N_CH-1:0]        iv_req_valid,
  input  logic [N_CH*LENGTH-1:0] iv_req_data,
  output logic [N_CH-1:0]        ov_req_ack,
  output logic [LENGTH-1:0]      ov_ser_din,
  output logic                   o_ser_din_valid,
  input  logic                   i_ser_ready,
  input  logic                   i_ser_dout_valid,
  output logic                   o_ser_ack,
  output logic [ID_W-1:0]        ov_grant_id,
  output logic                   o_busy,
  output logic                   o_frame_start,
  output logic                   o_frame_done,
  output logic                   o_error
);

  logic [3:0]        state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [LENGTH-1:0] din_q, din_d;
  logic              din_valid_q, din_valid_d;
  logic [N_CH-1:0]   req_ack_q, req_ack_d;
  logic              ser_ack_q, ser_ack_d;
  logic [ID_W-1:0]   grant_q, grant_d;
  logic              busy_q, busy_d;
  logic              start_q, start_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  logic [N_CH-1:0]   arb_gnt;
  logic [ID_W-1:0]   arb_id;
  logic              arb_any;
  logic              wd_expired;
  logic [ID_W-1:0]   next_ptr;

  rr_arbiter #(
    .N_CH (N_CH)
  ) u_arb (
    .req_i    (iv_req_valid),
    .ptr_i    (ptr_q),
    .gnt_o    (arb_gnt),
    .gnt_id_o (arb_id),
    .any_o    (arb_any)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    wd_d        = wd_q;
    din_d       = din_q;
    din_valid_d = din_valid_q;
    grant_d     = grant_q;
    req_ack_d   = '0;
    ser_ack_d   = 1'b0;
    start_d     = 1'b0;
    done_d      = 1'b0;
    error_d     = 1'b0;

    wd_expired = (TIMEOUT != 0) && (wd_q == WD_W'(TIMEOUT - 1));
    next_ptr   = (grant_q == ID_W'(N_CH - 1)) ? '0 : ID_W'(grant_q + 1'b1);

    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          state_d     = ST_LOAD;
          grant_d     = arb_id;
          din_d       = iv_req_data[int'(arb_id)*LENGTH +: LENGTH];
          req_ack_d   = arb_gnt;
          din_valid_d = 1'b1;
          wd_d        = '0;
        end
      end
      // The awaited event always wins over a same-cycle watchdog expiry.
      ST_LOAD: begin
        if (i_ser_ready) begin
          state_d     = ST_SHIFT;
          din_valid_d = 1'b0;
          start_d     = 1'b1;
          wd_d        = '0;
        end else if (wd_expired) begin
          state_d     = ST_IDLE;
          din_valid_d = 1'b0;
          error_d     = 1'b1;
          ptr_d       = next_ptr;
          wd_d        = '0;
        end else begin
          wd_d = WD_W'(wd_q + 1'b1);
        end
      end
      ST_SHIFT: begin
        if (i_ser_dout_valid) begin
          state_d   = ST_RELEASE;
          ser_ack_d = 1'b1;
          wd_d      = '0;
        end else if (wd_expired) begin
          state_d = ST_IDLE;
          error_d = 1'b1;
          ptr_d   = next_ptr;
          wd_d    = '0;
        end else begin
          wd_d = WD_W'(wd_q + 1'b1);
        end
      end
      ST_RELEASE: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        ptr_d   = next_ptr;
        wd_d    = '0;
      end
      default: begin
        state_d     = ST_IDLE;
        din_valid_d = 1'b0;
        wd_d        = '0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      wd_q        <= '0;
      din_q       <= '0;
      din_valid_q <= 1'b0;
      req_ack_q   <= '0;
      ser_ack_q   <= 1'b0;
      grant_q     <= '0;
      busy_q      <= 1'b0;
      start_q     <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else if (i_en) begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      wd_q        <= wd_d;
      din_q       <= din_d;
      din_valid_q <= din_valid_d;
      req_ack_q   <= req_ack_d;
      ser_ack_q   <= ser_ack_d;
      grant_q     <= grant_d;
      busy_q      <= busy_d;
      start_q     <= start_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign ov_req_ack      = req_ack_q;
  assign ov_ser_din      = din_q;
  assign o_ser_din_valid = din_valid_q;
  assign o_ser_ack       = ser_ack_q;
  assign ov_grant_id     = grant_q;
  assign o_busy          = busy_q;
  assign o_frame_start   = start_q;
  assign o_frame_done    = done_q;
  assign o_error         = error_q;

endmodule

// File: tb/tb_serializer_scheduler.sv
// Scoreboard bench for serializer_scheduler: expected grants are queued as
// requests are driven and checked when the scheduler acknowledges a source.
module tb_serializer_scheduler;

  localparam int unsigned N_CH    = 4;
  localparam int unsigned LENGTH  = 24;
  localparam int unsigned TIMEOUT = 64;
  localparam int unsigned ID_W    = 2;

  logic                   i_clk = 1'b0;
  logic                   i_rst_n;
  logic                   i_en;
  logic [N_CH-1:0]        iv_req_valid;
  logic [N_CH*LENGTH-1:0] iv_req_data;
  logic [N_CH-1:0]        ov_req_ack;
  logic [LENGTH-1:0]      ov_ser_din;
  logic                   o_ser_din_valid;
  logic                   i_ser_ready;
  logic                   i_ser_dout_valid;
  logic                   o_ser_ack;
  logic [ID_W-1:0]        ov_grant_id;
  logic                   o_busy;
  logic                   o_frame_start;
  logic                   o_frame_done;
  logic                   o_error;

  serializer_scheduler #(
    .N_CH    (N_CH),
    .LENGTH  (LENGTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .i_clk            (i_clk),
    .i_rst_n          (i_rst_n),
    .i_en             (i_en),
    .iv_req_valid     (iv_req_valid),
    .iv_req_data      (iv_req_data),
    .ov_req_ack       (ov_req_ack),
    .ov_ser_din       (ov_ser_din),
    .o_ser_din_valid  (o_ser_din_valid),
    .i_ser_ready      (i_ser_ready),
    .i_ser_dout_valid (i_ser_dout_valid),
    .o_ser_ack        (o_ser_ack),
    .ov_grant_id      (ov_grant_id),
    .o_busy           (o_busy),
    .o_frame_start    (o_frame_start),
    .o_frame_done     (o_frame_done),
    .o_error          (o_error)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [LENGTH-1:0] data;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int unsigned n_vec        = 0;
  int unsigned n_err        = 0;
  int unsigned ser_ack_cnt  = 0;
  int unsigned err_pulses   = 0;
  logic        prev_busy    = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [LENGTH-1:0] word_of(input int unsigned k);
    return {8'(8'h11 * (k + 1)), 16'(16'hC0DE + k)};
  endfunction

  task automatic push_exp(input int unsigned k);
    exp_t e;
    e.id   = ID_W'(k);
    e.data = word_of(k);
    exp_q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    cyc();
    i_rst_n = 1'b1;
    cyc();
  endtask

  // Returns in the cycle the ack/din_valid appear; a source drops its valid on ack.
  task automatic wait_grant(input logic drop);
    int unsigned n;
    n = 0;
    while (!o_ser_din_valid && n < 20) begin
      cyc();
      n++;
    end
    if (!o_ser_din_valid) chk("grant_timeout", 32'd0, 32'd1);
    if (drop) iv_req_valid = iv_req_valid & ~ov_req_ack;
  endtask

  // Serializer model: ready after rdly cycles, frame end after ddly more.
  task automatic serve(input int unsigned rdly, input int unsigned ddly);
    repeat (rdly) cyc();
    i_ser_ready = 1'b1;
    cyc();
    i_ser_ready = 1'b0;
    chk("frame_start", 32'(o_frame_start), 32'd1);
    chk("din_valid_drop", 32'(o_ser_din_valid), 32'd0);
    repeat (ddly) cyc();
    i_ser_dout_valid = 1'b1;
    cyc();
    i_ser_dout_valid = 1'b0;
    chk("ser_ack", 32'(o_ser_ack), 32'd1);
    cyc();
    chk("frame_done", 32'(o_frame_done), 32'd1);
    chk("ser_ack_clear", 32'(o_ser_ack), 32'd0);
    chk("busy_idle", 32'(o_busy), 32'd0);
  endtask

  always @(negedge i_clk) begin
    if (i_rst_n) begin
      if (|ov_req_ack) begin
        chk("ack_while_busy", 32'(prev_busy), 32'd0);
        if (exp_q.size() == 0) begin
          chk("unexpected_ack", 32'(ov_req_ack), 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("grant_id", 32'(ov_grant_id), 32'(mon_e.id));
          chk("ack_onehot", 32'(ov_req_ack), 32'd1 << mon_e.id);
          chk("ser_din", 32'(ov_ser_din), 32'(mon_e.data));
          chk("din_valid_with_ack", 32'(o_ser_din_valid), 32'd1);
          chk("busy_with_ack", 32'(o_busy), 32'd1);
        end
      end
      if (o_ser_ack) ser_ack_cnt++;
      if (o_error) err_pulses++;
    end
    prev_busy = o_busy;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int unsigned snap;
    logic        seen;

    i_rst_n          = 1'b0;
    i_en             = 1'b1;
    iv_req_valid     = '0;
    iv_req_data      = '0;
    i_ser_ready      = 1'b0;
    i_ser_dout_valid = 1'b0;
    for (int k = 0; k < N_CH; k++) iv_req_data[k*LENGTH +: LENGTH] = word_of(k);
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_ack", 32'(ov_req_ack), 32'd0);
    chk("rst_din", 32'(ov_ser_din), 32'd0);
    chk("rst_din_valid", 32'(o_ser_din_valid), 32'd0);
    chk("rst_grant", 32'(ov_grant_id), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_pulses", {28'd0, o_ser_ack, o_frame_start, o_frame_done, o_error}, 32'd0);
    i_rst_n = 1'b1;
    cyc();

    // Single channel 2 with the documented cycle offsets.
    iv_req_data[2*LENGTH +: LENGTH] = 24'hA5A5A5;
    exp_q.push_back({2'd2, 24'hA5A5A5});
    iv_req_valid = 4'b0100;
    cyc();
    chk("t1_ack_at_t1", 32'(ov_req_ack), 32'h4);
    iv_req_valid = '0;
    cyc();
    chk("t1_ack_one_cycle", 32'(ov_req_ack), 32'd0);
    chk("t1_din_hold", 32'(o_ser_din_valid), 32'd1);
    snap = ser_ack_cnt;
    serve(2, 25);
    chk("t1_ser_ack_once", ser_ack_cnt - snap, 32'd1);
    iv_req_data[2*LENGTH +: LENGTH] = word_of(2);

    // Fairness: all channels pending for eight frames.
    do_reset();
    for (int f = 0; f < 8; f++) push_exp(f % 4);
    iv_req_valid = '1;
    for (int f = 0; f < 8; f++) begin
      wait_grant(1'b0);
      serve(1, 2);
    end
    iv_req_valid = '0;
    chk("fair_queue_empty", exp_q.size(), 32'd0);

    // Wrap/skip from pointer 3 with only ch1 and ch3 pending.
    do_reset();
    push_exp(2);
    iv_req_valid = 4'b0100;
    wait_grant(1'b1);
    serve(1, 1);
    push_exp(3);
    push_exp(1);
    iv_req_valid = 4'b1010;
    wait_grant(1'b1);
    serve(1, 1);
    wait_grant(1'b1);
    serve(1, 1);
    push_exp(2);
    iv_req_valid = 4'b1101;
    wait_grant(1'b1);
    serve(1, 1);
    iv_req_valid = '0;

    // Watchdog: serializer never takes the word.
    push_exp(3);
    iv_req_valid = 4'b1011;
    wait_grant(1'b0);
    seen = 1'b0;
    for (int i = 1; i < 64; i++) begin
      cyc();
      if (o_error || !o_ser_din_valid) seen = 1'b1;
    end
    chk("wd_not_early", 32'(seen), 32'd0);
    cyc();
    chk("wd_error", 32'(o_error), 32'd1);
    chk("wd_din_valid_low", 32'(o_ser_din_valid), 32'd0);
    chk("wd_no_ser_ack", 32'(o_ser_ack), 32'd0);
    chk("wd_idle", 32'(o_busy), 32'd0);
    push_exp(0);
    wait_grant(1'b1);
    serve(1, 1);
    iv_req_valid = '0;

    // Enable freeze in SHIFT with dout_valid already high.
    push_exp(1);
    iv_req_valid = 4'b0010;
    wait_grant(1'b1);
    cyc();
    i_ser_ready = 1'b1;
    cyc();
    i_ser_ready = 1'b0;
    chk("fz_frame_start", 32'(o_frame_start), 32'd1);
    repeat (55) cyc();
    snap = ser_ack_cnt;
    i_en = 1'b0;
    i_ser_dout_valid = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      cyc();
      if (o_ser_ack || o_error || !o_busy) seen = 1'b1;
    end
    chk("fz_frozen", 32'(seen), 32'd0);
    i_en = 1'b1;
    cyc();
    chk("fz_ser_ack", 32'(o_ser_ack), 32'd1);
    i_ser_dout_valid = 1'b0;
    cyc();
    chk("fz_done", 32'(o_frame_done), 32'd1);
    chk("fz_ser_ack_once", ser_ack_cnt - snap, 32'd1);

    // Reset while in LOAD, then grant restarts from ch0.
    push_exp(2);
    iv_req_valid = 4'b0111;
    wait_grant(1'b0);
    cyc();
    i_rst_n = 1'b0;
    #2;
    chk("mr_din_valid", 32'(o_ser_din_valid), 32'd0);
    chk("mr_busy", 32'(o_busy), 32'd0);
    chk("mr_din", 32'(ov_ser_din), 32'd0);
    chk("mr_grant", 32'(ov_grant_id), 32'd0);
    chk("mr_pulses", {28'd0, o_ser_ack, o_frame_start, o_frame_done, o_error}, 32'd0);
    cyc();
    i_rst_n = 1'b1;
    push_exp(0);
    wait_grant(1'b1);
    iv_req_valid = '0;
    serve(1, 1);

    chk("scoreboard_empty", exp_q.size(), 32'd0);
    chk("error_pulse_count", err_pulses, 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
